rvfpm_issue_ctrl: RTL and testbench

// Issue/writeback controller for the rvfpm FP datapath. Sits between the decoder and the

---
 rtl/rvfpm_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_rvfpm_issue_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfpm_issue_ctrl.sv
// rvfpm issue/writeback controller: scoreboarded RAW/WAW stalls for a fixed-depth FP pipeline and
// arbitration of the single FP register-file write port between pipeline results and memory loads.
module rvfpm_issue_ctrl #(
   parameter int  NUM_REGS        = 32,
   parameter int  PIPELINE_STAGES = 4,
   parameter int  MAX_LOADS       = 4,
   parameter int  MEM_MAX_WAIT    = 3,
   localparam int AW              = $clog2(NUM_REGS)
) (
   input  logic            ck,
   input  logic            rst,
   input  logic            enable,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3*AW-1:0] req_rs,
   input  logic [2:0]      req_rs_used,
   input  logic [AW-1:0]   req_rd,
   input  logic            req_wr,
   input  logic            req_is_load,
   input  logic            mem_wb_valid,
   input  logic [AW-1:0]   mem_wb_rd,
   output logic            mem_wb_ready,
   output logic            pipe_adv,
   output logic            pipe_issue,
   output logic            wb_valid,
   output logic            wb_src,
   output logic [AW-1:0]   wb_rd,
   output logic            spur_wb,
   output logic            busy
);
   localparam int S   = PIPELINE_STAGES;
   localparam int LCW = $clog2(MAX_LOADS + 1);
   localparam int WCW = $clog2(MEM_MAX_WAIT + 1);
   localparam logic [LCW-1:0] LD_MAX   = LCW'(MAX_LOADS);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_MAX_WAIT);

   typedef struct packed {
      logic          valid;
      logic          wr;
      logic [AW-1:0] rd;
   } stage_t;

   stage_t              sv [S];
   logic [NUM_REGS-1:0] pend_pipe, pend_pipe_nxt;
   logic [NUM_REGS-1:0] pend_load, pend_load_nxt;
   logic [NUM_REGS-1:0] pend_all;
   logic [LCW-1:0]      ld_cnt, ld_cnt_nxt;
   logic [WCW-1:0]      wait_cnt, wait_cnt_nxt;
   logic                hazard, force_mem, pipe_wb, load_accept, load_retire;

   always_comb begin
      // NOTE: every combinational output is given a default first so no path can infer a latch.
      hazard   = 1'b0;
      pend_all = pend_pipe | pend_load;
      for (int i = 0; i < 3; i++) begin
         if (req_rs_used[i] && pend_all[req_rs[i*AW +: AW]]) hazard = 1'b1;
      end
      if (req_wr && pend_all[req_rd]) hazard = 1'b1;
   end

   // A load that has waited its full budget freezes the pipeline and takes the write port.
   assign force_mem    = mem_wb_valid && (wait_cnt == WAIT_MAX);
   assign pipe_adv     = enable && !rst && !force_mem;
   assign pipe_wb      = pipe_adv && !flush && sv[S-1].valid && sv[S-1].wr;
   assign mem_wb_ready = enable && !rst && mem_wb_valid && !pipe_wb;
   assign req_ready    = pipe_adv && !flush && !hazard && (!req_is_load || (ld_cnt < LD_MAX));
   assign pipe_issue   = req_valid && req_ready && !req_is_load;
   assign load_accept  = req_valid && req_ready && req_is_load;
   assign load_retire  = mem_wb_ready && pend_load[mem_wb_rd];
   assign spur_wb      = mem_wb_ready && !pend_load[mem_wb_rd];
   assign wb_valid     = pipe_wb || mem_wb_ready;
   assign wb_src       = mem_wb_ready;
   assign wb_rd        = pipe_wb ? sv[S-1].rd : (mem_wb_ready ? mem_wb_rd : '0);

   always_comb begin
      busy = (ld_cnt != '0);
      for (int i = 0; i < S; i++) busy = busy | sv[i].valid;
   end

   always_comb begin
      pend_pipe_nxt = pend_pipe;
      pend_load_nxt = pend_load;
      ld_cnt_nxt    = ld_cnt;
      wait_cnt_nxt  = wait_cnt;
      if (pipe_wb) pend_pipe_nxt[sv[S-1].rd] = 1'b0;
      if (pipe_issue && req_wr) pend_pipe_nxt[req_rd] = 1'b1;
      if (flush) pend_pipe_nxt = '0;
      // Set after clear: a spurious grant to the same reg must not cancel a newly accepted load.
      if (mem_wb_ready) pend_load_nxt[mem_wb_rd] = 1'b0;
      if (load_accept) pend_load_nxt[req_rd] = 1'b1;
      case ({load_accept, load_retire})
         2'b10:   ld_cnt_nxt = ld_cnt + 1'b1;
         2'b01:   ld_cnt_nxt = ld_cnt - 1'b1;
         default: ld_cnt_nxt = ld_cnt;
      endcase
      if (mem_wb_ready) wait_cnt_nxt = '0;
      else if (mem_wb_valid) wait_cnt_nxt = wait_cnt + 1'b1;
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         // NOTE: the stage array is reset explicitly; its valid bits gate writebacks and busy.
         for (int i = 0; i < S; i++) sv[i] <= '0;
         pend_pipe <= '0;
         pend_load <= '0;
         ld_cnt    <= '0;
         wait_cnt  <= '0;
      end else if (enable) begin
         if (flush) begin
            for (int i = 0; i < S; i++) sv[i] <= '0;
         end else if (pipe_adv) begin
            // NOTE: non-blocking assignments make every stage read its pre-edge neighbour.
            sv[0] <= '{valid: pipe_issue, wr: req_wr, rd: req_rd};
            for (int i = 1; i < S; i++) sv[i] <= sv[i-1];
         end
         pend_pipe <= pend_pipe_nxt;
         pend_load <= pend_load_nxt;
         ld_cnt    <= ld_cnt_nxt;
         wait_cnt  <= wait_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Self-checking bench for rvfpm_issue_ctrl: an in-flight-op list model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rvfpm_issue_ctrl;
   localparam int NUM_REGS     = 32;
   localparam int S            = 4;
   localparam int MAX_LOADS    = 4;
   localparam int MEM_MAX_WAIT = 3;
   localparam int AW           = 5;

   logic            ck = 1'b0;
   logic            rst, enable, flush;
   logic            req_valid, req_ready;
   logic [3*AW-1:0] req_rs;
   logic [2:0]      req_rs_used;
   logic [AW-1:0]   req_rd;
   logic            req_wr, req_is_load;
   logic            mem_wb_valid, mem_wb_ready;
   logic [AW-1:0]   mem_wb_rd;
   logic            pipe_adv, pipe_issue, wb_valid, wb_src, spur_wb, busy;
   logic [AW-1:0]   wb_rd;

   int n_checks = 0;
   int n_errs   = 0;

   rvfpm_issue_ctrl #(
      .NUM_REGS(NUM_REGS), .PIPELINE_STAGES(S), .MAX_LOADS(MAX_LOADS), .MEM_MAX_WAIT(MEM_MAX_WAIT)
   ) dut (
      .ck(ck), .rst(rst), .enable(enable), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rs_used(req_rs_used),
      .req_rd(req_rd), .req_wr(req_wr), .req_is_load(req_is_load),
      .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_ready(mem_wb_ready),
      .pipe_adv(pipe_adv), .pipe_issue(pipe_issue), .wb_valid(wb_valid), .wb_src(wb_src),
      .wb_rd(wb_rd), .spur_wb(spur_wb), .busy(busy)
   );

   always #5 ck = ~ck;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: in-flight ops carry the number of advances they have made; loads are a pending set.
   typedef struct {
      int rd;
      bit wr;
      int age;
   } op_t;

   typedef struct {
      bit ready, adv, issue, mready, pwb, wbv, src, spur, busy;
      int wrd;
   } exp_t;

   op_t  inflight[$];
   op_t  nq[$];
   bit   pl [NUM_REGS];
   int   wait_m = 0;
   exp_t e_m;

   function automatic bit pend_any(int r);
      if (pl[r]) return 1'b1;
      foreach (inflight[i]) if (inflight[i].wr && inflight[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model_eval();
      exp_t e;
      int   nld = 0;
      int   ret = -1;
      bit   haz = 1'b0;
      bit   frc;
      foreach (pl[r]) if (pl[r]) nld++;
      foreach (inflight[i]) if (inflight[i].age == S-1) ret = i;
      for (int j = 0; j < 3; j++)
         if (req_rs_used[j] && pend_any(int'(req_rs[j*AW +: AW]))) haz = 1'b1;
      if (req_wr && pend_any(int'(req_rd))) haz = 1'b1;
      frc      = mem_wb_valid && (wait_m == MEM_MAX_WAIT);
      e.adv    = enable && !rst && !frc;
      e.pwb    = e.adv && !flush && (ret >= 0) && inflight[ret].wr;
      e.mready = enable && !rst && mem_wb_valid && !e.pwb;
      e.ready  = e.adv && !flush && !haz && (!req_is_load || nld < MAX_LOADS);
      e.issue  = req_valid && e.ready && !req_is_load;
      e.wbv    = e.pwb || e.mready;
      e.src    = e.mready;
      e.wrd    = e.pwb ? inflight[ret].rd : (e.mready ? int'(mem_wb_rd) : 0);
      e.spur   = e.mready && !pl[mem_wb_rd];
      e.busy   = !rst && (inflight.size() > 0 || nld > 0);
      return e;
   endfunction

   // Inputs change just after the rising edge, so at the falling edge they are the values
   // the DUT will see at the next edge: compare, then advance the model across that edge.
   always @(negedge ck) begin
      e_m = model_eval();
      check("req_ready",    req_ready,    e_m.ready);
      check("pipe_adv",     pipe_adv,     e_m.adv);
      check("pipe_issue",   pipe_issue,   e_m.issue);
      check("mem_wb_ready", mem_wb_ready, e_m.mready);
      check("wb_valid",     wb_valid,     e_m.wbv);
      check("wb_src",       wb_src,       e_m.src);
      check("wb_rd",        wb_rd,        e_m.wrd);
      check("spur_wb",      spur_wb,      e_m.spur);
      check("busy",         busy,         e_m.busy);
      if (rst) begin
         inflight.delete();
         foreach (pl[r]) pl[r] = 1'b0;
         wait_m = 0;
      end else if (enable) begin
         if (flush) begin
            inflight.delete();
         end else if (e_m.adv) begin
            nq.delete();
            foreach (inflight[i]) begin
               if (inflight[i].age < S-1) begin
                  op_t o;
                  o = inflight[i];
                  o.age++;
                  nq.push_back(o);
               end
            end
            if (e_m.issue) nq.push_back('{rd: int'(req_rd), wr: req_wr, age: 0});
            inflight = nq;
         end
         if (e_m.mready) pl[mem_wb_rd] = 1'b0;
         if (req_valid && e_m.ready && req_is_load) pl[req_rd] = 1'b1;
         if (e_m.mready) wait_m = 0;
         else if (mem_wb_valid) wait_m++;
      end
   end

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic mid();
      @(negedge ck);
   endtask

   task automatic idle();
      flush = 0; req_valid = 0; req_rs = '0; req_rs_used = '0; req_rd = '0;
      req_wr = 0; req_is_load = 0; mem_wb_valid = 0; mem_wb_rd = '0;
   endtask

   task automatic set_op(input int rd, input bit wr, input int rs1, input logic [2:0] used,
                         input bit is_load);
      req_valid   = 1;
      req_rd      = AW'(rd);
      req_wr      = wr;
      req_rs      = {AW'(0), AW'(0), AW'(rs1)};
      req_rs_used = used;
      req_is_load = is_load;
   endtask

   task automatic drain(input int n);
      repeat (n) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  k;
      int  j;
      bit  saw5;

      // Reset with active inputs: everything must stay low.
      idle();
      rst = 1; enable = 1;
      set_op(1, 1, 0, 3'b000, 0);
      mem_wb_valid = 1; mem_wb_rd = 3;
      mid();
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_ready", mem_wb_ready, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_busy", busy, 0);
      step();
      rst = 0; idle();
      step();

      // Back-to-back independent ops f1..f4.
      for (int i = 0; i < 4; i++) begin
         set_op(i + 1, 1, 0, 3'b000, 0);
         mid();
         check("b2b_ready", req_ready, 1);
         check("b2b_issue", pipe_issue, 1);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         mid();
         check("b2b_wb_valid", wb_valid, 1);
         check("b2b_wb_rd", wb_rd, i + 1);
         step();
      end
      mid();
      check("b2b_idle_busy", busy, 0);
      step();

      // RAW on f5: four stall cycles, issue the cycle after wb_rd=5.
      set_op(5, 1, 0, 3'b000, 0);
      mid();
      check("raw_prod_ready", req_ready, 1);
      step();
      set_op(6, 1, 5, 3'b001, 0);
      k = 0; saw5 = 0;
      while (k < 20) begin
         mid();
         if (req_ready) break;
         saw5 = wb_valid && (wb_rd == 5);
         k++;
         step();
      end
      check("raw_stall_cycles", k, 4);
      check("raw_wb5_before_issue", saw5, 1);
      check("raw_consumer_issue", pipe_issue, 1);
      step();
      idle();
      drain(6);

      // Load limit: four outstanding, fifth stalls until one returns.
      for (int i = 0; i < 4; i++) begin
         set_op(10 + i, 1, 0, 3'b000, 1);
         mid();
         check("ld_ready", req_ready, 1);
         check("ld_no_issue", pipe_issue, 0);
         step();
      end
      set_op(14, 1, 0, 3'b000, 1);
      mid();
      check("ld5_blocked", req_ready, 0);
      check("ld_busy", busy, 1);
      step();
      mem_wb_valid = 1; mem_wb_rd = 10;
      mid();
      check("ld5_grant_ready", mem_wb_ready, 1);
      check("ld5_still_blocked", req_ready, 0);
      step();
      mem_wb_valid = 0;
      mid();
      check("ld5_accepted", req_ready, 1);
      step();
      idle();
      for (int i = 0; i < 4; i++) begin
         mem_wb_valid = 1; mem_wb_rd = AW'(11 + i);
         mid();
         check("ld_ret_src", wb_src, 1);
         check("ld_ret_rd", wb_rd, 11 + i);
         step();
      end
      idle();
      mid();
      check("ld_done_busy", busy, 0);
      step();

      // Bounded wait: pipeline writes every cycle while a load waits.
      set_op(30, 1, 0, 3'b000, 1);
      mid();
      step();
      j = 0;
      for (int i = 0; i < 9; i++) begin
         set_op(16 + (j % 8), 1, 0, 3'b000, 0);
         mem_wb_valid = (i >= 4 && i <= 7);
         mem_wb_rd    = 30;
         mid();
         if (i >= 4 && i <= 6) begin
            check("wait_denied", mem_wb_ready, 0);
            check("wait_pipe_src", wb_src, 0);
         end
         if (i == 7) begin
            check("force_adv", pipe_adv, 0);
            check("force_src", wb_src, 1);
            check("force_rd", wb_rd, 30);
         end
         if (i == 8) begin
            check("resume_adv", pipe_adv, 1);
            check("resume_wb", wb_valid, 1);
            check("resume_src", wb_src, 0);
         end
         if (pipe_issue) j++;
         step();
      end
      idle();
      drain(6);

      // Flush three in-flight ops.
      for (int i = 0; i < 3; i++) begin
         set_op(7 + i, 1, 0, 3'b000, 0);
         step();
      end
      idle(); flush = 1;
      mid();
      check("flush_no_ready", req_ready, 0);
      check("flush_no_wb", wb_valid, 0);
      step();
      idle();
      set_op(8, 1, 7, 3'b001, 0);
      mid();
      check("flush_busy", busy, 0);
      check("flush_reissue", req_ready, 1);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         mid();
         check("flush_no_old_wb", wb_valid, 0);
         step();
      end
      mid();
      check("flush_new_wb_rd", wb_rd, 8);
      step();

      // Enable low freezes everything, flush ignored.
      set_op(12, 1, 0, 3'b000, 0);
      step();
      enable = 0; flush = 1;
      set_op(13, 1, 0, 3'b000, 0);
      mem_wb_valid = 1; mem_wb_rd = 9;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("dis_ready", req_ready, 0);
         check("dis_mem_ready", mem_wb_ready, 0);
         check("dis_busy", busy, 1);
         step();
      end
      enable = 1; idle();
      for (int i = 0; i < 3; i++) begin
         mid();
         check("dis_late_no_wb", wb_valid, 0);
         step();
      end
      mid();
      check("dis_late_wb_rd", wb_rd, 12);
      step();

      // Spurious memory writeback leaves the load count alone.
      set_op(3, 1, 0, 3'b000, 1);
      step();
      idle();
      mem_wb_valid = 1; mem_wb_rd = 9;
      mid();
      check("spur_pulse", spur_wb, 1);
      check("spur_wb_valid", wb_valid, 1);
      step();
      mem_wb_rd = 3;
      mid();
      check("spur_real_ret", spur_wb, 0);
      step();
      idle();
      mid();
      check("spur_cnt_busy", busy, 0);
      step();

      // Reset mid-pipeline.
      set_op(20, 1, 0, 3'b000, 0);
      step();
      set_op(21, 1, 0, 3'b000, 0);
      step();
      set_op(22, 1, 0, 3'b000, 1);
      step();
      rst = 1;
      set_op(23, 1, 0, 3'b000, 0);
      mem_wb_valid = 1; mem_wb_rd = 22;
      mid();
      check("mrst_ready", req_ready, 0);
      check("mrst_adv", pipe_adv, 0);
      check("mrst_wb", wb_valid, 0);
      check("mrst_rd", wb_rd, 0);
      check("mrst_spur", spur_wb, 0);
      check("mrst_busy", busy, 0);
      step();
      rst = 0; idle();
      set_op(24, 1, 20, 3'b001, 0);
      mid();
      check("mrst_after_busy", busy, 0);
      check("mrst_after_ready", req_ready, 1);
      step();
      idle();
      drain(6);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
